// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared state encoding, opcode and ALU-operation constants
//               for the multi-cycle CPU control path.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'd0,
        ST_FETCH1  = 5'd1,
        ST_FETCH1W = 5'd2,
        ST_FETCH2  = 5'd3,
        ST_FETCH2W = 5'd4,
        ST_DECODE  = 5'd5,
        ST_LD1     = 5'd6,
        ST_LD2     = 5'd7,
        ST_ST1     = 5'd8,
        ST_ST2     = 5'd9,
        ST_AL1     = 5'd10,
        ST_AL2     = 5'd11,
        ST_AL3     = 5'd12,
        ST_AL4     = 5'd13,
        ST_AL5     = 5'd14,
        ST_AL6     = 5'd15,
        ST_JMP1    = 5'd16,
        ST_HALT    = 5'd17
    } state_t;

    localparam logic [3:0] C_OP_LOAD  = 4'h0;
    localparam logic [3:0] C_OP_STORE = 4'h1;
    localparam logic [3:0] C_OP_ADD   = 4'h4;
    localparam logic [3:0] C_OP_ADC   = 4'h5;
    localparam logic [3:0] C_OP_SUB   = 4'h6;
    localparam logic [3:0] C_OP_AND   = 4'h7;
    localparam logic [3:0] C_OP_JMP   = 4'h8;
    localparam logic [3:0] C_OP_BRC   = 4'h9;
    localparam logic [3:0] C_OP_HALT  = 4'hF;

    localparam logic [1:0] C_ALUOP_ADD = 2'b00;
    localparam logic [1:0] C_ALUOP_ADC = 2'b01;
    localparam logic [1:0] C_ALUOP_SUB = 2'b10;
    localparam logic [1:0] C_ALUOP_AND = 2'b11;

    // flags are packed {C,Z,N}; select 00 is an unconditional branch
    function automatic logic brc_taken(input logic [1:0] jmpsel, input logic [2:0] flags);
        case (jmpsel)
            2'b01:   brc_taken = flags[2];
            2'b10:   brc_taken = flags[1];
            2'b11:   brc_taken = flags[0];
            default: brc_taken = 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
// Module      : control_decode
// Description : Moore output decoder - maps the current control state to the
//               datapath strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module control_decode
    import cpu_pkg::*;
(
    input  state_t     i_state,
    input  logic [1:0] i_alu_sel,
    output logic       o_pcsrc,
    output logic       o_pcld_en,
    output logic       o_pcout,
    output logic       o_irld_l,
    output logic       o_irld_r,
    output logic       o_dild,
    output logic       o_iraout,
    output logic       o_irdout,
    output logic       o_mout,
    output logic       o_rout,
    output logic       o_alures_out,
    output logic       o_mld,
    output logic       o_mem_write,
    output logic       o_rld,
    output logic       o_reg_write,
    output logic       o_reg_sel,
    output logic       o_regfile_sel,
    output logic       o_ald,
    output logic       o_bld,
    output logic       o_alures_ld,
    output logic       o_czn_ld,
    output logic [1:0] o_aluop,
    output logic       o_halted
);

    assign o_aluop  = i_alu_sel;
    assign o_irdout = 1'b0;

    always_comb begin
        o_pcsrc       = 1'b0;
        o_pcld_en     = 1'b0;
        o_pcout       = 1'b0;
        o_irld_l      = 1'b0;
        o_irld_r      = 1'b0;
        o_dild        = 1'b0;
        o_iraout      = 1'b0;
        o_mout        = 1'b0;
        o_rout        = 1'b0;
        o_alures_out  = 1'b0;
        o_mld         = 1'b0;
        o_mem_write   = 1'b0;
        o_rld         = 1'b0;
        o_reg_write   = 1'b0;
        o_reg_sel     = 1'b0;
        o_regfile_sel = 1'b0;
        o_ald         = 1'b0;
        o_bld         = 1'b0;
        o_alures_ld   = 1'b0;
        o_czn_ld      = 1'b0;
        o_halted      = 1'b0;
        case (i_state)
            ST_FETCH1, ST_FETCH2: begin
                o_pcout = 1'b1;
                o_mld   = 1'b1;
            end
            ST_FETCH1W: begin
                o_mout    = 1'b1;
                o_irld_l  = 1'b1;
                o_pcld_en = 1'b1;
            end
            ST_FETCH2W: begin
                o_mout    = 1'b1;
                o_irld_r  = 1'b1;
                o_dild    = 1'b1;
                o_pcld_en = 1'b1;
            end
            ST_LD1: begin
                o_iraout = 1'b1;
                o_mld    = 1'b1;
            end
            ST_LD2: begin
                o_mout        = 1'b1;
                o_reg_write   = 1'b1;
                o_reg_sel     = 1'b1;
                o_regfile_sel = 1'b1;
            end
            ST_ST1, ST_AL1: begin
                o_rld         = 1'b1;
                o_reg_sel     = 1'b1;
                o_regfile_sel = 1'b1;
            end
            ST_ST2: begin
                o_iraout    = 1'b1;
                o_rout      = 1'b1;
                o_mem_write = 1'b1;
            end
            ST_AL2: begin
                o_rout = 1'b1;
                o_ald  = 1'b1;
            end
            // source accumulator: RegSel stays 0
            ST_AL3: begin
                o_rld         = 1'b1;
                o_regfile_sel = 1'b1;
            end
            ST_AL4: begin
                o_rout = 1'b1;
                o_bld  = 1'b1;
            end
            ST_AL5: begin
                o_alures_ld = 1'b1;
                o_czn_ld    = 1'b1;
            end
            ST_AL6: begin
                o_alures_out  = 1'b1;
                o_reg_write   = 1'b1;
                o_reg_sel     = 1'b1;
                o_regfile_sel = 1'b1;
            end
            ST_JMP1: begin
                o_iraout  = 1'b1;
                o_pcsrc   = 1'b1;
                o_pcld_en = 1'b1;
            end
            ST_HALT: o_halted = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Multi-cycle CPU control FSM - state register, next-state
//               dispatch and the Moore output decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic [2:0] FlagOut,
    input  logic [1:0] JmpSel,
    output logic       PCsrc,
    output logic       PCldEn,
    output logic       PCout,
    output logic       IRldL,
    output logic       IRldR,
    output logic       DIld,
    output logic       IRAout,
    output logic       IRDout,
    output logic       Mout,
    output logic       Rout,
    output logic       ALUResOut,
    output logic       Mld,
    output logic       MemWrite,
    output logic       Rld,
    output logic       RegWrite,
    output logic       RegSel,
    output logic       RegFileSel,
    output logic       Ald,
    output logic       Bld,
    output logic       ALUResld,
    output logic       CZNld,
    output logic [1:0] ALUOp,
    output logic       halted
);

    state_t r_state;
    state_t w_next;
    logic   r_run;

    // r_run holds the FSM in IDLE for the first edge after release, so the
    // first FETCH1 lands on the second rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run   <= 1'b0;
            r_state <= ST_IDLE;
        end else begin
            r_run   <= 1'b1;
            r_state <= r_run ? w_next : ST_IDLE;
        end
    end

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:    w_next = ST_FETCH1;
            ST_FETCH1:  w_next = ST_FETCH1W;
            ST_FETCH1W: w_next = ST_FETCH2;
            ST_FETCH2:  w_next = ST_FETCH2W;
            ST_FETCH2W: w_next = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    C_OP_LOAD:  w_next = ST_LD1;
                    C_OP_STORE: w_next = ST_ST1;
                    C_OP_ADD, C_OP_ADC, C_OP_SUB, C_OP_AND: w_next = ST_AL1;
                    C_OP_JMP:   w_next = ST_JMP1;
                    C_OP_BRC:   w_next = brc_taken(JmpSel, FlagOut) ? ST_JMP1 : ST_FETCH1;
                    C_OP_HALT:  w_next = ST_HALT;
                    default:    w_next = ST_FETCH1;
                endcase
            end
            ST_LD1:  w_next = ST_LD2;
            ST_ST1:  w_next = ST_ST2;
            ST_AL1:  w_next = ST_AL2;
            ST_AL2:  w_next = ST_AL3;
            ST_AL3:  w_next = ST_AL4;
            ST_AL4:  w_next = ST_AL5;
            ST_AL5:  w_next = ST_AL6;
            ST_LD2, ST_ST2, ST_AL6, ST_JMP1: w_next = ST_FETCH1;
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_IDLE;
        endcase
    end

    control_decode u_decode (
        .i_state       (r_state),
        .i_alu_sel     (opcode[1:0]),
        .o_pcsrc       (PCsrc),
        .o_pcld_en     (PCldEn),
        .o_pcout       (PCout),
        .o_irld_l      (IRldL),
        .o_irld_r      (IRldR),
        .o_dild        (DIld),
        .o_iraout      (IRAout),
        .o_irdout      (IRDout),
        .o_mout        (Mout),
        .o_rout        (Rout),
        .o_alures_out  (ALUResOut),
        .o_mld         (Mld),
        .o_mem_write   (MemWrite),
        .o_rld         (Rld),
        .o_reg_write   (RegWrite),
        .o_reg_sel     (RegSel),
        .o_regfile_sel (RegFileSel),
        .o_ald         (Ald),
        .o_bld         (Bld),
        .o_alures_ld   (ALUResld),
        .o_czn_ld      (CZNld),
        .o_aluop       (ALUOp),
        .o_halted      (halted)
    );

endmodule
`default_nettype wire

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 opcode  input  4  instruction opcode from the instruction register.
REQ-004 FlagOut  input  3  {C,Z,N} flag register contents.
REQ-005 JmpSel  input  2  branch-condition select, captured alongside the second instruction byte.
REQ-006 PCsrc, PCldEn, PCout  output  1 each  PC mux select (0 = increment, 1 = address bus); PC load; PC drives address bus.
REQ-007 IRldL, IRldR, DIld  output  1 each  load first instruction byte; load second instruction byte; load DI.
REQ-008 IRAout, IRDout, Mout, Rout, ALUResOut  output  1 each  bus drivers; IRDout is held 0.
REQ-009 Mld, MemWrite, Rld, RegWrite, RegSel, RegFileSel  output  1 each  memory and register-file controls; RegSel 1 selects the destination accumulator, 0 the source accumulator.
REQ-010 Ald, Bld, ALUResld, CZNld  output  1 each  ALU operand, result and flag loads.
REQ-011 ALUOp  output  2  00 ADD, 01 ADC, 10 SUB, 11 AND.
REQ-012 halted  output  1  high while in HALT.

Function
REQ-013 The block SHALL be a Moore FSM: every output is a function of the current state only, with no output registers.
REQ-014 Every output not listed for a state SHALL be 0 in that state.
REQ-015 IDLE state outputs: all 0; next state FETCH1.
REQ-016 Fetch sequence:
- FETCH1: PCout, Mld.
- FETCH1W: Mout, IRldL, PCldEn (PCsrc = 0).
- FETCH2: PCout, Mld.
- FETCH2W: Mout, IRldR, DIld, PCldEn (PCsrc = 0).
- Then DECODE.
REQ-017 DECODE SHALL assert no outputs and dispatch on opcode:
- 0x0 LOAD -> LD1; 0x1 STORE -> ST1.
- 0x4-0x7 -> AL1 with ALU operation ADD/ADC/SUB/AND = opcode[1:0].
- 0x8 JMP -> JMP1; 0x9 BRC -> JMP1 if condition true, else FETCH1.
- 0xF -> HALT; every other opcode -> FETCH1 (NOP).
REQ-018 BRC condition SHALL be selected by JmpSel: 00 always true, 01 C, 10 Z, 11 N (FlagOut bits 2, 1, 0).
REQ-019 LOAD states:
- LD1: IRAout, Mld.
- LD2: Mout, RegWrite, RegSel = 1, RegFileSel = 1; then FETCH1.
REQ-020 STORE states:
- ST1: Rld, RegSel = 1, RegFileSel = 1.
- ST2: IRAout, Rout, MemWrite; then FETCH1.
REQ-021 ALU states:
- AL1: Rld, RegSel = 1, RegFileSel = 1.
- AL2: Rout, Ald.
- AL3: Rld, RegSel = 0, RegFileSel = 1.
- AL4: Rout, Bld.
- AL5: ALUResld, CZNld, ALUOp = opcode[1:0].
- AL6: ALUResOut, RegWrite, RegSel = 1, RegFileSel = 1; then FETCH1.
REQ-022 ALUOp SHALL equal opcode[1:0] in every state.
REQ-023 JMP1: IRAout, PCsrc = 1, PCldEn; then FETCH1.
REQ-024 Instruction latency SHALL be counted from FETCH1 to the next FETCH1:
- LOAD 7, STORE 7, ALU 11, JMP 6 cycles.
- BRC 6 cycles taken, 5 not taken; NOP 5 cycles.
REQ-025 HALT SHALL assert halted, hold all other outputs 0, and remain in HALT until reset.
REQ-026 Within any single state, at most one of IRAout and PCout SHALL be high, and at most one of Mout, Rout and ALUResOut SHALL be high.
REQ-027 Unused and undefined state encodings SHALL transition to IDLE.

Reset
REQ-028 rst low SHALL force IDLE immediately, asynchronously; all outputs 0 and halted 0 while rst is low.
REQ-029 Reset asserted mid-instruction SHALL abandon the instruction with no further strobes.
REQ-030 The first FETCH1 SHALL occur on the second rising edge after rst is released.

Structure
REQ-031 Package cpu_pkg SHALL hold:
- the state enum;
- opcode constants (LOAD, STORE, ADD, ADC, SUB, AND, JMP, BRC, HALT);
- ALUOp constants.
REQ-032 The design SHALL consist of a state register plus a next-state block inside control_unit and one sub-module, control_decode, that maps state to output strobes.

Verification
REQ-033 Release rst, program LOAD (0x0) from address 0x0123 -> PCout,Mld in cycles 1 and 3; Mld with IRAout at cycle 6; RegWrite at cycle 7; FETCH1 at cycle 8.
REQ-034 ADD (0x4) -> strobe order Rld, Ald, Rld, Bld, ALUResld+CZNld (ALUOp 00), RegWrite; 11 cycles total.
REQ-035 BRC (0x9), JmpSel = 10: with FlagOut = 3'b010 -> JMP1 asserts PCsrc=1 and PCldEn; with FlagOut = 3'b000 -> FETCH1 directly after DECODE.
REQ-036 HALT (0xF) -> halted=1, all strobes 0 for 20 cycles; pulse rst low -> IDLE, halted=0.
REQ-037 Assert rst low during AL3 -> all outputs 0 within the same cycle; after release: IDLE, then FETCH1.
REQ-038 Random opcode stream, 2000 instructions -> REQ-026 bus-exclusivity assertion never fires and opcode 0xB behaves as NOP (5 cycles).
